uart_rx: RTL and testbench
==========================

UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, meaning payload bits per frame.
REQ-002 SHALL have parameter PRESCALE, default 8, meaning CLK cycles per bit; legal values are 8, 16, 32.
REQ-003 SHALL have port CLK  input  1  oversampling clock at PRESCALE x baud; the only clock.
REQ-004 SHALL have port RST  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port RX_IN  input  1  serial line; idles high; already synchronised to CLK.
REQ-006 SHALL have port PAR_EN  input  1  1 = frame carries a parity bit.
REQ-007 SHALL have port PAR_TYP  input  1  0 = even parity, 1 = odd parity.
REQ-008 SHALL have port P_DATA  output  DATA_WIDTH  last good received word.
REQ-009 SHALL have port DATA_VALID  output  1  one-cycle pulse when a good word is presented on P_DATA.
REQ-010 SHALL have port PAR_ERR  output  1  one-cycle pulse on a parity mismatch.
REQ-011 SHALL have port STP_ERR  output  1  one-cycle pulse on a bad stop bit.

Function
REQ-012 SHALL accept frames of start(0), DATA_WIDTH data bits LSB first, optional parity, and stop(1).
REQ-013 SHALL implement FSM states IDLE, START, DATA, PARITY, STOP.
REQ-014 SHALL treat the IDLE cycle in which RX_IN=0 as edge count 0 of the start bit and enter START.
REQ-015 SHALL keep an edge counter 0..PRESCALE-1 per bit, wrapping to 0 at each bit boundary, plus a data-bit counter 0..DATA_WIDTH-1.
REQ-016 SHALL take RX_IN samples at edge counts PRESCALE/2-1, PRESCALE/2 and PRESCALE/2+1, with the bit value being the majority of the three.
REQ-017 SHALL return START to IDLE at edge count PRESCALE/2+1 if the sampled start bit is 1 (glitch), with no output pulse.
REQ-018 SHALL shift sampled data bits into an internal register LSB first, leaving P_DATA untouched during reception.
REQ-019 SHALL latch PAR_EN and PAR_TYP at start detection; changes mid-frame SHALL NOT affect the current frame.
REQ-020 SHALL move DATA to PARITY after the last data bit if the latched PAR_EN=1, otherwise to STOP.
REQ-021 SHALL set the expected parity to the XOR of the data bits for even parity, and to its inverse for odd parity.
REQ-022 SHALL treat a stop sample of 0 as a stop error.
REQ-023 SHALL return STOP to IDLE at edge count PRESCALE-1 of the stop bit; all status is reported in the following cycle.
REQ-024 SHALL, in that cycle, pulse DATA_VALID and load P_DATA only if there was neither a parity error nor a stop error.
REQ-025 SHALL, in the same cycle, pulse PAR_ERR and/or STP_ERR independently; both MAY assert together.
REQ-026 SHALL hold P_DATA from its last load until the next good frame.
REQ-027 SHALL detect a new start bit in the very cycle IDLE is re-entered, so back-to-back frames are received.
REQ-028 SHALL make a frame last (2+DATA_WIDTH+PAR_EN) x PRESCALE cycles from start detection to the status cycle.

Reset
REQ-029 SHALL, while RST=1, asynchronously force IDLE, clear all counters, P_DATA=0, DATA_VALID=0, PAR_ERR=0 and STP_ERR=0.
REQ-030 SHALL abort a frame in progress when RST asserts mid-frame, with no pulse, and await a fresh start bit after release.

Verification (PRESCALE=8, DATA_WIDTH=8; cycle 0 = start detection)
REQ-031 SHALL cover: 0xA5 with PAR_EN=0 and a good stop -> DATA_VALID pulse at cycle 80 with P_DATA=0xA5, no errors.
REQ-032 SHALL cover: 0x3C with even parity, parity bit 0 -> DATA_VALID at cycle 88 with P_DATA=0x3C.
REQ-033 SHALL cover: 0x01 with odd parity and parity bit 1 sent -> PAR_ERR pulse at cycle 88, DATA_VALID=0, P_DATA unchanged.
REQ-034 SHALL cover: 0x55 with PAR_EN=0 and stop bit 0 -> STP_ERR pulse at cycle 80, DATA_VALID=0.
REQ-035 SHALL cover: RX_IN low for 2 cycles then high -> FSM back in IDLE by cycle 5, no pulses; a following 0x0F frame is received correctly.
REQ-036 SHALL cover: RST asserted at cycle 30 of a 0xFF frame -> all outputs 0 at once; a 0x81 frame after release gives DATA_VALID with P_DATA=0x81.

Source files
------------

// File: rtl/uart_rx.sv
// UART receiver: oversampled start detection, 3-sample majority voting per bit,
// optional even/odd parity, single-cycle status pulses after the stop bit.
module uart_rx #(
    parameter int DATA_WIDTH = 8,
    parameter int PRESCALE   = 8
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  RX_IN,
    input  logic                  PAR_EN,
    input  logic                  PAR_TYP,
    output logic [DATA_WIDTH-1:0] P_DATA,
    output logic                  DATA_VALID,
    output logic                  PAR_ERR,
    output logic                  STP_ERR
);

    localparam int EW = $clog2(PRESCALE);
    localparam int BW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

    state_t                state, next_state;
    logic [EW-1:0]         edge_cnt;
    logic [BW-1:0]         bit_cnt;
    logic                  s0, s1;
    logic [DATA_WIDTH-1:0] shreg;
    logic                  par_en_l, par_typ_l;
    logic                  par_bad, stp_bad;

    logic mid_early, mid, mid_late, last_edge, last_bit, sample_bit;

    assign mid_early  = (edge_cnt == EW'(PRESCALE/2 - 1));
    assign mid        = (edge_cnt == EW'(PRESCALE/2));
    assign mid_late   = (edge_cnt == EW'(PRESCALE/2 + 1));
    assign last_edge  = (edge_cnt == EW'(PRESCALE - 1));
    assign last_bit   = (bit_cnt == BW'(DATA_WIDTH - 1));
    // third sample is the live line value, voted against the two stored ones
    assign sample_bit = (s0 & s1) | (s0 & RX_IN) | (s1 & RX_IN);

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) state <= IDLE;
        else     state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (!RX_IN) next_state = START;
            START: begin
                if (mid_late && sample_bit) next_state = IDLE;
                else if (last_edge)         next_state = DATA;
            end
            DATA:    if (last_edge && last_bit) next_state = par_en_l ? PARITY : STOP;
            PARITY:  if (last_edge) next_state = STOP;
            STOP:    if (last_edge) next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            edge_cnt   <= '0;
            bit_cnt    <= '0;
            s0         <= 1'b0;
            s1         <= 1'b0;
            shreg      <= '0;
            par_en_l   <= 1'b0;
            par_typ_l  <= 1'b0;
            par_bad    <= 1'b0;
            stp_bad    <= 1'b0;
            P_DATA     <= '0;
            DATA_VALID <= 1'b0;
            PAR_ERR    <= 1'b0;
            STP_ERR    <= 1'b0;
        end else begin
            DATA_VALID <= 1'b0;
            PAR_ERR    <= 1'b0;
            STP_ERR    <= 1'b0;

            if (state == IDLE) begin
                bit_cnt <= '0;
                // the detection cycle itself is edge 0 of the start bit
                if (!RX_IN) begin
                    edge_cnt  <= EW'(1);
                    par_en_l  <= PAR_EN;
                    par_typ_l <= PAR_TYP;
                    par_bad   <= 1'b0;
                    stp_bad   <= 1'b0;
                end else begin
                    edge_cnt  <= '0;
                end
            end else begin
                if (last_edge || next_state == IDLE) edge_cnt <= '0;
                else                                 edge_cnt <= edge_cnt + EW'(1);

                if (mid_early) s0 <= RX_IN;
                if (mid)       s1 <= RX_IN;

                case (state)
                    DATA: begin
                        if (mid_late)
                            shreg <= DATA_WIDTH'({sample_bit, shreg} >> 1);
                        if (last_edge)
                            bit_cnt <= last_bit ? '0 : bit_cnt + BW'(1);
                    end
                    PARITY: begin
                        if (mid_late)
                            par_bad <= (sample_bit != ((^shreg) ^ par_typ_l));
                    end
                    STOP: begin
                        if (mid_late) stp_bad <= ~sample_bit;
                        if (last_edge) begin
                            DATA_VALID <= ~par_bad & ~stp_bad;
                            PAR_ERR    <= par_bad;
                            STP_ERR    <= stp_bad;
                            if (!par_bad && !stp_bad) P_DATA <= shreg;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_uart_rx.sv
// Bench for uart_rx: directed frames with a scoreboard of expected status pulses,
// including glitch rejection, parity/stop errors, back-to-back and mid-frame reset.
module tb_uart_rx;

    logic       CLK = 1'b0;
    logic       RST;
    logic       RX_IN;
    logic       PAR_EN;
    logic       PAR_TYP;
    logic [7:0] P_DATA;
    logic       DATA_VALID;
    logic       PAR_ERR;
    logic       STP_ERR;

    uart_rx #(.DATA_WIDTH(8), .PRESCALE(8)) dut (
        .CLK        (CLK),
        .RST        (RST),
        .RX_IN      (RX_IN),
        .PAR_EN     (PAR_EN),
        .PAR_TYP    (PAR_TYP),
        .P_DATA     (P_DATA),
        .DATA_VALID (DATA_VALID),
        .PAR_ERR    (PAR_ERR),
        .STP_ERR    (STP_ERR)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic [7:0] data;
        logic       dv;
        logic       pe;
        logic       se;
        int         cyc;
    } exp_t;

    exp_t       q[$];
    exp_t       mon_e;
    int         total = 0;
    int         bad   = 0;
    int         cyc   = 0;
    logic [7:0] last_good = 8'h00;

    always @(posedge CLK) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // status pulses are consumed from the scoreboard as they appear
    always @(negedge CLK) begin
        if (!RST && (DATA_VALID || PAR_ERR || STP_ERR)) begin
            if (q.size() == 0) begin
                check("spurious_pulse", {29'd0, DATA_VALID, PAR_ERR, STP_ERR}, 32'd0);
            end else begin
                mon_e = q.pop_front();
                check("data_valid", {31'd0, DATA_VALID}, {31'd0, mon_e.dv});
                check("par_err",    {31'd0, PAR_ERR},    {31'd0, mon_e.pe});
                check("stp_err",    {31'd0, STP_ERR},    {31'd0, mon_e.se});
                check("p_data",     {24'd0, P_DATA},     {24'd0, mon_e.data});
                check("status_cycle", cyc, mon_e.cyc);
            end
        end
    end

    task automatic idle(input int n);
        RX_IN = 1'b1;
        repeat (n) @(negedge CLK);
    endtask

    // drive one frame starting at a negedge; abort_at >= 0 asserts RST at that cycle
    task automatic send(input logic [7:0] data, input logic pen, input logic ptyp,
                        input logic pbit, input logic stopb, input logic scramble,
                        input int abort_at);
        logic bits [0:10];
        int   n;
        exp_t e;
        n = pen ? 11 : 10;
        bits[0] = 1'b0;
        for (int i = 0; i < 8; i++) bits[1+i] = data[i];
        if (pen) begin
            bits[9]  = pbit;
            bits[10] = stopb;
        end else begin
            bits[9]  = stopb;
            bits[10] = 1'b1;
        end
        PAR_EN  = pen;
        PAR_TYP = ptyp;
        if (abort_at < 0) begin
            e.pe   = pen && (pbit != ((^data) ^ ptyp));
            e.se   = ~stopb;
            e.dv   = ~e.pe & ~e.se;
            e.data = e.dv ? data : last_good;
            e.cyc  = cyc + n * 8;
            last_good = e.data;
            q.push_back(e);
        end
        for (int c = 0; c < n * 8; c++) begin
            if (c == abort_at) begin
                RST = 1'b1;
                #1;
                check("rst_p_data",     {24'd0, P_DATA},     32'd0);
                check("rst_data_valid", {31'd0, DATA_VALID}, 32'd0);
                check("rst_par_err",    {31'd0, PAR_ERR},    32'd0);
                check("rst_stp_err",    {31'd0, STP_ERR},    32'd0);
                RX_IN = 1'b1;
                last_good = 8'h00;
                repeat (3) @(negedge CLK);
                RST = 1'b0;
                return;
            end
            RX_IN = bits[c/8];
            if (scramble && c == 4) begin
                PAR_EN  = ~pen;
                PAR_TYP = ~ptyp;
            end
            @(negedge CLK);
        end
    endtask

    initial begin
        RST     = 1'b1;
        RX_IN   = 1'b1;
        PAR_EN  = 1'b0;
        PAR_TYP = 1'b0;
        repeat (3) @(negedge CLK);
        check("reset_p_data",     {24'd0, P_DATA},     32'd0);
        check("reset_data_valid", {31'd0, DATA_VALID}, 32'd0);
        check("reset_par_err",    {31'd0, PAR_ERR},    32'd0);
        check("reset_stp_err",    {31'd0, STP_ERR},    32'd0);
        RST = 1'b0;
        idle(4);

        send(8'hA5, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, -1);   // plain good frame
        send(8'h3C, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, -1);   // even parity, controls flipped mid-frame
        send(8'h01, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, -1);   // odd parity violated
        send(8'h55, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, -1);   // bad stop
        idle(4);
        send(8'h01, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, -1);   // parity and stop both bad
        idle(4);

        RX_IN = 1'b0;                                    // 2-cycle glitch
        repeat (2) @(negedge CLK);
        idle(12);

        send(8'h0F, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, -1);
        send(8'hC3, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, -1);   // back-to-back, odd parity ok
        send(8'hFF, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 30);   // reset at cycle 30
        idle(4);
        send(8'h81, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, -1);

        RX_IN = 1'b1;
        for (int i = 0; i < 200 && q.size() != 0; i++) @(negedge CLK);
        check("scoreboard_drained", q.size(), 32'd0);
        idle(20);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
